tdm_demux8: RTL



---
 rtl/tdm_pkg.sv | 16 +
 rtl/tdm_slot_cnt.sv | 37 +++
 rtl/tdm_demux8.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared types and sizes for the tdm_demux8 deserializer
//
// Purpose: frame geometry (slots per frame, slot index width), error counter
// width and the receive FSM state encoding.
package tdm_pkg;

  localparam int SLOTS    = 8;
  localparam int SLOT_W   = 3;
  localparam int ERRCNT_W = 8;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_slot_cnt.sv
// rtl/tdm_slot_cnt.sv - 3-bit slot index counter for the TDM deserializer
//
// Purpose: tracks which slot the next valid beat lands in.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load1       beat stored as slot 0 on a frame marker; next slot is 1
//   inc         beat stored at the current slot; advance modulo 8
//   slot        current slot index
//   wrap        current slot is the last slot of the frame
module tdm_slot_cnt
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load1,
  input  logic              inc,
  output logic [SLOT_W-1:0] slot,
  output logic              wrap
);

  logic [SLOT_W-1:0] slot_q;

  // load1 wins over inc: a realigning beat always restarts the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else if (load1) begin
      slot_q <= SLOT_W'(1);
    end else if (inc) begin
      slot_q <= slot_q + SLOT_W'(1);
    end
  end

  assign slot = slot_q;
  assign wrap = (slot_q == SLOT_W'(SLOTS - 1));

endmodule

// File: rtl/tdm_demux8.sv
// rtl/tdm_demux8.sv - 8-slot TDM demultiplexer / deserializer with frame realignment
//
// Purpose: collects one slot per valid beat, realigns on frame_sync and
// publishes the eight slots as one parallel word with a one-cycle pulse.
// Optional feature macro: TDM_DEMUX_ERRCNT_EN (saturating sync-error counter).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   din          serial slot data (WIDTH bits)
//   din_valid    din carries a slot this cycle
//   frame_sync   marks the beat as slot 0 (only when din_valid)
//   slot         slot index the next valid beat is stored into
//   dout         parallel frame, slot k at dout[k*WIDTH +: WIDTH]
//   dout_valid   one-cycle pulse when dout is updated
//   sync_err     one-cycle pulse after a misaligned frame_sync
//   err_cnt      saturating sync-error count (0 when the counter is not built)
module tdm_demux8
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       din,
  input  logic                   din_valid,
  input  logic                   frame_sync,
  output logic [SLOT_W-1:0]      slot,
  output logic [SLOTS*WIDTH-1:0] dout,
  output logic                   dout_valid,
  output logic                   sync_err,
  output logic [ERRCNT_W-1:0]    err_cnt
);

  // Shadow holds slots 0..6 only; slot 7 goes straight into dout.
  localparam int SHW = (SLOTS - 1) * WIDTH;

  state_t                 state_q, state_d;
  logic [SHW-1:0]         shadow_q;
  logic [SLOTS*WIDTH-1:0] dout_q;
  logic                   dout_valid_q;
  logic                   sync_err_q;

  logic                   cnt_load;
  logic                   cnt_inc;
  logic                   wr_zero;
  logic                   wr_cur;
  logic                   publish;
  logic                   err_d;
  logic                   wrap;

  tdm_slot_cnt u_slot_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load1 (cnt_load),
    .inc   (cnt_inc),
    .slot  (slot),
    .wrap  (wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    wr_zero  = 1'b0;
    wr_cur   = 1'b0;
    publish  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      HUNT: begin
        if (din_valid && frame_sync) begin
          cnt_load = 1'b1;
          wr_zero  = 1'b1;
          state_d  = COLLECT;
        end
      end
      COLLECT: begin
        if (din_valid) begin
          if (frame_sync && (slot != '0)) begin
            // Misaligned marker: drop the partial frame, restart at slot 0.
            err_d    = 1'b1;
            cnt_load = 1'b1;
            wr_zero  = 1'b1;
          end else begin
            // Free-running: a marker at slot 0 is just a normal slot-0 beat.
            cnt_inc = 1'b1;
            if (wrap) begin
              publish = 1'b1;
            end else begin
              wr_cur = 1'b1;
            end
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else begin
      for (int k = 0; k < SLOTS - 1; k++) begin
        if ((wr_zero && (k == 0)) || (wr_cur && (slot == SLOT_W'(k)))) begin
          shadow_q[k*WIDTH +: WIDTH] <= din;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      if (publish) begin
        dout_q <= {din, shadow_q};
      end
      dout_valid_q <= publish;
      sync_err_q   <= err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign sync_err   = sync_err_q;

`ifdef TDM_DEMUX_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (err_d && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERRCNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule
